// File: rtl/picosoc_timer.sv
// picosoc_timer: programmable down-counting interval timer on the PicoSoC iomem bus.
// Word map on iomem_addr[4:2]: CTRL, PRESCALE, LOAD, COUNT, STATUS, CYCLES, 2 reserved.
// Optional feature macro: PICOSOC_TIMER_CYCLES_EN builds the free-running CYCLES
// counter at word 5; without it word 5 reads 0.
// Reset is synchronous and active-low (resetn).
module picosoc_timer #(
    parameter int CLOCK_SPEED_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq_o
);

    // Prescaler reset value gives a 1 us tick at the logic clock rate.
    localparam logic [15:0] PRESCALE_RST = 16'(CLOCK_SPEED_HZ / 1_000_000 - 1);

    localparam logic [2:0] W_CTRL     = 3'd0;
    localparam logic [2:0] W_PRESCALE = 3'd1;
    localparam logic [2:0] W_LOAD     = 3'd2;
    localparam logic [2:0] W_COUNT    = 3'd3;
    localparam logic [2:0] W_STATUS   = 3'd4;
    localparam logic [2:0] W_CYCLES   = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    bus_state_t  state_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        irqen_q, irqen_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pre_q, pre_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;

    logic [2:0]  word;
    logic        accept;
    logic        wr_any;
    logic [31:0] wmask;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_load;
    logic        wr_count;
    logic        status_clr;
    logic        tick;
    logic        expire;
    logic [31:0] rd_word;
    logic [31:0] cycles_val;

    // Only the word index is decoded; the rest of the address is consumed here.
    logic unused_addr;
    assign unused_addr = ^{iomem_addr[31:5], iomem_addr[1:0]};

    assign word   = iomem_addr[4:2];
    // A request is only taken from IDLE; anything seen during ACK is dropped.
    assign accept = (state_q == ST_IDLE) && iomem_valid;
    assign wr_any = accept && (iomem_wstrb != 4'b0000);

    // Per-byte write mask built from the strobes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    // CTRL and STATUS live entirely in byte 0, so only strobe 0 can touch them.
    assign wr_ctrl     = wr_any && (word == W_CTRL) && iomem_wstrb[0];
    assign wr_prescale = wr_any && (word == W_PRESCALE);
    assign wr_load     = wr_any && (word == W_LOAD);
    assign wr_count    = wr_any && (word == W_COUNT);
    assign status_clr  = wr_any && (word == W_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    // Prescaler reaching its terminal value produces one tick; a tick with
    // COUNT already at zero is an expiry.
    assign tick   = en_q && (pre_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);

    assign irq_o       = expired_q & irqen_q;
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;

`ifdef PICOSOC_TIMER_CYCLES_EN
    logic [31:0] cycles_q;

    // Free-running cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles_val = cycles_q;
`else
    assign cycles_val = 32'd0;
`endif

    // Next-state for the timer registers, including the collision priorities:
    // bus writes to COUNT/CTRL override the tick, and an expiry overrides a
    // STATUS clear.
    always_comb begin
        en_d       = en_q;
        reload_d   = reload_q;
        irqen_d    = irqen_q;
        prescale_d = prescale_q;
        pre_d      = pre_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;

        // One-shot expiry stops the timer.
        if (expire && !reload_q) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d     = iomem_wdata[0];
            reload_d = iomem_wdata[1];
            irqen_d  = iomem_wdata[2];
        end

        // Prescaler only runs while enabled and restarts on an enable edge.
        if (en_q) begin
            pre_d = tick ? 16'd0 : (pre_q + 16'd1);
        end
        if (wr_ctrl && !en_q && iomem_wdata[0]) begin
            pre_d = 16'd0;
        end

        // Only the low two bytes of PRESCALE exist.
        if (wr_prescale) begin
            prescale_d = (prescale_q & ~wmask[15:0]) | (iomem_wdata[15:0] & wmask[15:0]);
        end

        if (wr_load) begin
            load_d = (load_q & ~wmask) | (iomem_wdata & wmask);
        end

        // COUNT never goes below zero; it only wraps through LOAD.
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (reload_q) begin
                count_d = load_q;
            end
        end
        if (wr_count) begin
            count_d = (count_q & ~wmask) | (iomem_wdata & wmask);
        end

        if (status_clr) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // Timer register file.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            irqen_q    <= 1'b0;
            prescale_q <= PRESCALE_RST;
            pre_q      <= 16'd0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            reload_q   <= reload_d;
            irqen_q    <= irqen_d;
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end

    // Read mux: values as they stand in the request cycle.
    always_comb begin
        rd_word = 32'd0;
        case (word)
            W_CTRL:     rd_word = {29'd0, irqen_q, reload_q, en_q};
            W_PRESCALE: rd_word = {16'd0, prescale_q};
            W_LOAD:     rd_word = load_q;
            W_COUNT:    rd_word = count_q;
            W_STATUS:   rd_word = {31'd0, expired_q};
            W_CYCLES:   rd_word = cycles_val;
            default:    rd_word = 32'd0;
        endcase
    end

    // Bus handshake: accept in IDLE, pulse ready with latched data in ACK.
    // rdata is forced to zero outside the ready pulse so the upstream OR mux is safe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iomem_valid) begin
                        state_q <= ST_ACK;
                        ready_q <= 1'b1;
                        rdata_q <= rd_word;
                    end else begin
                        ready_q <= 1'b0;
                        rdata_q <= 32'd0;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= 32'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_timer.sv
// Testbench for picosoc_timer: scoreboarded bus reads, an interrupt expectation
// table, directed timing/collision cases and randomised timer runs checked
// against a closed-form model of the tick/reload arithmetic.
module tb_picosoc_timer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    picosoc_timer #(.CLOCK_SPEED_HZ(50_000_000)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (valid),
        .iomem_wstrb (wstrb),
        .iomem_addr  (addr),
        .iomem_wdata (wdata),
        .iomem_rdata (rdata),
        .iomem_ready (ready),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle k is the interval after the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int rel_cyc  = 0;

    typedef struct {
        int          issue;
        logic        chk;
        logic [31:0] data;
        string       name;
    } txn_t;

    txn_t sb[$];
    bit   irq_exp[int];

    // Closed-form timer model parameters for the current run.
    int m_c, m_p, m_L, m_C0, m_rel, m_irqen;

    // Ticks that have taken effect by cycle t after the enabling CTRL write in cycle m_c.
    function automatic int ticks_at(int t);
        if (t - 1 - m_c < 0) return 0;
        return (t - 1 - m_c) / (m_p + 1);
    endfunction

    function automatic logic [31:0] count_at(int t);
        int m;
        m = ticks_at(t);
        if (m <= m_C0) return 32'(m_C0 - m);
        if (m_rel != 0) return 32'(m_L - ((m - m_C0 - 1) % (m_L + 1)));
        return 32'd0;
    endfunction

    function automatic logic exp_at(int t);
        return ticks_at(t) > m_C0;
    endfunction

    function automatic logic en_at(int t);
        return (m_rel != 0) || (ticks_at(t) <= m_C0);
    endfunction

    function automatic logic [31:0] cycles_exp(int t);
`ifdef PICOSOC_TIMER_CYCLES_EN
        return 32'(t - rel_cyc);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: pops the scoreboard on each ready pulse, checks latency/data,
    // idle rdata and scheduled irq levels.
    txn_t mt;
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            checks++;
            if (ready_prev === 1'b1) begin
                failures++;
                $display("FAIL ready_width cycle=%0d got=ready_twice exp=single_pulse", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready cycle=%0d got=1 exp=0", cyc);
            end else begin
                mt = sb.pop_front();
                checks++;
                if (cyc != mt.issue + 1) begin
                    failures++;
                    $display("FAIL %s_latency got=%0d exp=%0d", mt.name, cyc - mt.issue, 1);
                end
                if (mt.chk) begin
                    checks++;
                    if (rdata !== mt.data) begin
                        failures++;
                        $display("FAIL %s cycle=%0d got=%08h exp=%08h", mt.name, mt.issue, rdata, mt.data);
                    end
                end
                $display("txn %-12s issue=%0d ack=%0d rdata=%08h", mt.name, mt.issue, cyc, rdata);
            end
        end else begin
            checks++;
            if (rdata !== 32'd0) begin
                failures++;
                $display("FAIL rdata_idle cycle=%0d got=%08h exp=00000000", cyc, rdata);
            end
        end
        if (irq_exp.exists(cyc)) begin
            checks++;
            if (irq !== irq_exp[cyc]) begin
                failures++;
                $display("FAIL irq cycle=%0d got=%b exp=%b", cyc, irq, irq_exp[cyc]);
            end
            irq_exp.delete(cyc);
        end
        ready_prev = ready;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endtask

    // One bus transfer, entered and left #1 after a rising edge. valid is held
    // through the ACK cycle like the CPU does, then dropped.
    task automatic xfer(input logic [2:0] w, input logic [3:0] s, input logic [31:0] d,
                        input logic c, input logic [31:0] e, input string nm);
        txn_t t;
        valid = 1'b1;
        wstrb = s;
        addr  = $urandom();
        addr[4:2] = w;
        wdata = d;
        t.issue = cyc;
        t.chk   = c;
        t.data  = e;
        t.name  = nm;
        sb.push_back(t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b0;
        wstrb = 4'h0;
        wdata = $urandom();
    endtask

    task automatic wr(input logic [2:0] w, input logic [31:0] d);
        xfer(w, 4'hF, d, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [2:0] w, input logic [31:0] e, input string nm);
        xfer(w, 4'h0, $urandom(), 1'b1, e, nm);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        summary();
        $finish;
    end

    initial begin
        int t;
        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = 32'd0;
        wdata  = 32'd0;
        m_c = 0; m_p = 0; m_L = 0; m_C0 = 0; m_rel = 0; m_irqen = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        resetn  = 1'b1;
        rel_cyc = cyc;
        @(posedge clk); #1;

        // Reset values of every word.
        rd(3'd0, 32'd0, "rst_ctrl");
        rd(3'd1, 32'd49, "rst_prescale");
        rd(3'd2, 32'd0, "rst_load");
        rd(3'd3, 32'd0, "rst_count");
        rd(3'd4, 32'd0, "rst_status");
        rd(3'd5, cycles_exp(cyc), "cycles_a");
        rd(3'd6, 32'd0, "rst_word6");
        rd(3'd7, 32'd0, "rst_word7");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'd0, "word6_ro");
        t = cyc + 10;
        wait_until(t - 10 + 10);
        rd(3'd5, cycles_exp(cyc), "cycles_b");

        // Periodic mode with a tick every cycle, plus STATUS clear collision.
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd3);
        m_p = 0; m_L = 3; m_C0 = 3; m_rel = 1; m_irqen = 1;
        m_c = cyc;
        irq_exp[m_c + 4] = 1'b0;
        irq_exp[m_c + 5] = 1'b1;
        irq_exp[m_c + 7] = 1'b0;
        irq_exp[m_c + 8] = 1'b0;
        irq_exp[m_c + 9] = 1'b1;
        wr(3'd0, 32'd7);
        wait_until(m_c + 6);
        wr(3'd4, 32'd1);
        wait_until(m_c + 8);
        wr(3'd4, 32'd1);
        rd(3'd4, 32'd1, "stat_coll");
        rd(3'd3, count_at(cyc), "per_count");
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);

        // One-shot: 6 ticks of 10 cycles each.
        wr(3'd1, 32'd9);
        wr(3'd3, 32'd5);
        m_p = 9; m_L = 0; m_C0 = 5; m_rel = 0; m_irqen = 1;
        m_c = cyc;
        irq_exp[m_c + 60] = 1'b0;
        irq_exp[m_c + 61] = 1'b1;
        wr(3'd0, 32'd5);
        wait_until(m_c + 35);
        rd(3'd3, count_at(cyc), "os_mid");
        wait_until(m_c + 62);
        rd(3'd0, 32'd4, "os_ctrl");
        rd(3'd3, 32'd0, "os_count");
        rd(3'd4, 32'd1, "os_status");
        wr(3'd4, 32'd1);

        // CTRL write landing on a one-shot expiry: written EN survives.
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd2);
        m_c = cyc;
        wr(3'd0, 32'd1);
        wait_until(m_c + 3);
        wr(3'd0, 32'd3);
        rd(3'd0, 32'd3, "ctrl_coll");
        wr(3'd0, 32'd0);

        // COUNT write landing on a tick: written value, no decrement.
        wr(3'd1, 32'd9);
        wr(3'd3, 32'd5);
        m_c = cyc;
        wr(3'd0, 32'd1);
        wait_until(m_c + 20);
        wr(3'd3, 32'h20);
        rd(3'd3, 32'h20, "count_coll");
        wr(3'd0, 32'd0);

        // Byte-lane writes.
        wr(3'd2, 32'hFFFF_FFFF);
        xfer(3'd2, 4'b0010, 32'h0000_AB00, 1'b0, 32'd0, "write_b1");
        rd(3'd2, 32'hFFFF_ABFF, "load_byte");
        wr(3'd1, 32'hDEAD_1234);
        rd(3'd1, 32'h0000_1234, "pre_upper");
        xfer(3'd1, 4'b0001, 32'h0000_00FF, 1'b0, 32'd0, "write_b0");
        rd(3'd1, 32'h0000_12FF, "pre_byte");

        // Randomised runs against the closed-form model.
        for (int i = 0; i < 40; i++) begin
            wr(3'd0, 32'd0);
            wr(3'd4, 32'd1);
            m_p     = int'($urandom_range(0, 3));
            m_L     = int'($urandom_range(0, 5));
            m_C0    = int'($urandom_range(0, 6));
            m_rel   = int'($urandom_range(0, 1));
            m_irqen = int'($urandom_range(0, 1));
            wr(3'd1, 32'(m_p));
            wr(3'd2, 32'(m_L));
            wr(3'd3, 32'(m_C0));
            m_c = cyc;
            wr(3'd0, {29'd0, m_irqen[0], m_rel[0], 1'b1});
            wait_until(cyc + int'($urandom_range(0, 40)));
            t = cyc;
            irq_exp[t] = exp_at(t) & m_irqen[0];
            rd(3'd3, count_at(t), "rnd_count");
            rd(3'd4, {31'd0, exp_at(cyc)}, "rnd_status");
            rd(3'd0, {29'd0, m_irqen[0], m_rel[0], en_at(cyc)}, "rnd_ctrl");
            rd(3'd3, count_at(cyc), "rnd_count2");
        end

        // Reset asserted with a request pending and the timer running.
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd7);
        repeat (6) begin @(posedge clk); #1; end
        valid  = 1'b1;
        addr   = 32'h0900_000C;
        resetn = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        resetn  = 1'b1;
        rel_cyc = cyc;
        @(posedge clk); #1;
        rd(3'd0, 32'd0, "rst2_ctrl");
        rd(3'd1, 32'd49, "rst2_prescale");
        rd(3'd3, 32'd0, "rst2_count");
        rd(3'd4, 32'd0, "rst2_status");
        rd(3'd5, cycles_exp(cyc), "rst2_cycles");

        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_ready got=%0d exp=0", sb.size());
        end
        checks++;
        if (irq_exp.size() != 0) begin
            failures++;
            $display("FAIL irq_unchecked got=%0d exp=0", irq_exp.size());
        end
        summary();
        $finish;
    end

endmodule
